// File: rtl/v810_busarb.sv
// Memory access unit bus arbiter: one external memory bus shared by the instruction
// port (IC*) and the EU data port (D*); data first, with a starvation cap and watchdog.
module v810_busarb #(
  parameter int unsigned DMAX = 4,
  parameter int unsigned TMO  = 0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] ICIA,
  output logic [31:0] ICID,
  input  logic        ICIREQ,
  output logic        ICIACK,
  input  logic [31:0] DA,
  input  logic [31:0] DWD,
  input  logic [3:0]  DBE,
  input  logic        DWE,
  output logic [31:0] DRD,
  input  logic        DREQ,
  output logic        DACK,
  output logic [31:0] MA,
  output logic [31:0] MWD,
  output logic [3:0]  MBE,
  output logic        MWE,
  input  logic [31:0] MRD,
  output logic        MREQ,
  input  logic        MACK,
  output logic        BERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } st_t;

  localparam logic [3:0] DMAX_C   = 4'(DMAX);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 32'd1);
  localparam logic       WDOG_EN  = (TMO != 32'd0);

  st_t        st_q, st_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       granted_s;
  logic       wdog_hit_s;

  assign granted_s  = (st_q == GNT_I) || (st_q == GNT_D);
  // Watchdog fires on the TMO-th granted CE cycle that still has no MACK.
  assign wdog_hit_s = WDOG_EN && granted_s && CE && !MACK && (tcnt_q == TMO_LAST);

  assign ICID = MRD;
  assign DRD  = MRD;

  // State register.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      st_q   <= IDLE;
      dcnt_q <= 4'd0;
      tcnt_q <= 8'd0;
    end else begin
      st_q   <= st_d;
      dcnt_q <= dcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  // Next-state: arbitration in IDLE, completion/watchdog while granted.
  always_comb begin
    st_d   = st_q;
    dcnt_d = dcnt_q;
    tcnt_d = tcnt_q;
    if (CE) begin
      case (st_q)
        IDLE: begin
          // dcnt only counts data grants that overtook a waiting instruction request.
          if (DREQ && !(ICIREQ && (dcnt_q >= DMAX_C))) begin
            st_d = GNT_D;
            if (ICIREQ) begin
              dcnt_d = (dcnt_q == 4'hF) ? 4'hF : dcnt_q + 4'd1;
            end else begin
              dcnt_d = 4'd0;
            end
          end else if (ICIREQ) begin
            st_d   = GNT_I;
            dcnt_d = 4'd0;
          end else begin
            st_d = IDLE;
          end
        end
        GNT_I, GNT_D: begin
          if (MACK || wdog_hit_s) begin
            st_d   = TURN;
            tcnt_d = 8'd0;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
        TURN: begin
          st_d = IDLE;
        end
        default: begin
          st_d = IDLE;
        end
      endcase
    end else begin
      st_d = st_q;
    end
  end

  // Outputs: bus steered from the granted requester, MACK routed to its ACK only.
  always_comb begin
    MREQ   = 1'b0;
    MA     = 32'd0;
    MWD    = 32'd0;
    MBE    = 4'd0;
    MWE    = 1'b0;
    ICIACK = 1'b0;
    DACK   = 1'b0;
    BERR   = 1'b0;
    case (st_q)
      GNT_I: begin
        MREQ   = 1'b1;
        MA     = ICIA;
        MBE    = 4'hF;
        ICIACK = MACK | wdog_hit_s;
        BERR   = wdog_hit_s;
      end
      GNT_D: begin
        MREQ = 1'b1;
        MA   = DA;
        MWD  = DWD;
        MBE  = DBE;
        MWE  = DWE;
        DACK = MACK | wdog_hit_s;
        BERR = wdog_hit_s;
      end
      default: begin
        MREQ = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_v810_busarb.sv
// Bench for v810_busarb: randomized requesters and memory, checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_v810_busarb;

  localparam int DMAX = 4;
  localparam int TMO  = 8;

  logic        CLK = 1'b0;
  logic        RES, CE, ICIREQ, DREQ, DWE, MACK;
  logic [31:0] ICIA, DA, DWD, MRD;
  logic [3:0]  DBE;
  logic [31:0] ICID, DRD, MA, MWD;
  logic [3:0]  MBE;
  logic        ICIACK, DACK, MWE, MREQ, BERR;

  v810_busarb #(.DMAX(DMAX), .TMO(TMO)) dut (
    .CLK(CLK), .RES(RES), .CE(CE),
    .ICIA(ICIA), .ICID(ICID), .ICIREQ(ICIREQ), .ICIACK(ICIACK),
    .DA(DA), .DWD(DWD), .DBE(DBE), .DWE(DWE), .DRD(DRD), .DREQ(DREQ), .DACK(DACK),
    .MA(MA), .MWD(MWD), .MBE(MBE), .MWE(MWE), .MRD(MRD), .MREQ(MREQ), .MACK(MACK),
    .BERR(BERR)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: ph 0=bus free, 1=owned by 'owner' (1=instr, 2=data), 2=turnaround.
  int ph = 0, owner = 0, streak = 0, wt = 0, lat = 0;

  // Stimulus knobs and requester/memory bookkeeping.
  int ce_pct = 100, lat_min = 0, lat_max = 0, raise_pct = 100, cool_max = 0;
  bit ce_alt = 1'b0, no_ack = 1'b0, noise = 1'b0, wr_only = 1'b0, i_en = 1'b0, d_en = 1'b0;
  int i_cool = 0, d_cool = 0;
  bit e_iack = 1'b0, e_dack = 1'b0;
  int grant_cyc = 0, n_berr = 0;
  bit rec = 1'b0;
  byte seq[$];
  string exp_seq = "DDDDIDDDDI";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Advance model and requesters with the inputs that were present at the edge.
  task automatic on_edge();
    bit i_done, d_done;
    if (RES) begin
      ph = 0; owner = 0; streak = 0; wt = 0;
      return;
    end
    if (!CE) return;
    i_done = e_iack;
    d_done = e_dack;
    case (ph)
      0: begin
        if (DREQ && !(ICIREQ && streak >= DMAX)) begin
          ph = 1; owner = 2;
          streak = ICIREQ ? ((streak < 15) ? streak + 1 : 15) : 0;
          lat = $urandom_range(lat_max, lat_min);
        end else if (ICIREQ) begin
          ph = 1; owner = 1; streak = 0;
          lat = $urandom_range(lat_max, lat_min);
        end
        wt = 0;
      end
      1: begin
        if (MACK || wt == TMO - 1) begin
          ph = 2; wt = 0;
        end else begin
          wt++;
          if (lat > 0) lat--;
        end
      end
      default: ph = 0;
    endcase
    if (i_done) begin
      ICIREQ = 1'b0; i_cool = 1 + $urandom_range(cool_max, 0);
    end else if (!ICIREQ && i_cool > 0) i_cool--;
    if (d_done) begin
      DREQ = 1'b0; d_cool = 1 + $urandom_range(cool_max, 0);
    end else if (!DREQ && d_cool > 0) d_cool--;
  endtask

  task automatic drive();
    CE  = ce_alt ? ~CE : ($urandom_range(99, 0) < ce_pct);
    MRD = $urandom();
    if (!ICIREQ && i_cool == 0 && i_en && $urandom_range(99, 0) < raise_pct) begin
      ICIREQ = 1'b1; ICIA = $urandom();
    end
    if (!DREQ && d_cool == 0 && d_en && $urandom_range(99, 0) < raise_pct) begin
      DREQ = 1'b1; DA = $urandom(); DWD = $urandom(); DBE = 4'($urandom());
      DWE = wr_only ? 1'b1 : 1'($urandom());
    end
    if (ph == 1) MACK = !no_ack && lat == 0;
    else MACK = noise && ($urandom_range(3, 0) == 0);
  endtask

  task automatic check();
    bit g, to;
    g  = (ph == 1);
    to = g && CE && !MACK && (wt == TMO - 1);
    e_iack = g && owner == 1 && (MACK || to);
    e_dack = g && owner == 2 && (MACK || to);
    chk("MREQ",   32'(MREQ),   32'(g));
    chk("ICIACK", 32'(ICIACK), 32'(e_iack));
    chk("DACK",   32'(DACK),   32'(e_dack));
    chk("BERR",   32'(BERR),   32'(to));
    chk("MA",     MA,  !g ? 32'd0 : (owner == 1 ? ICIA : DA));
    chk("MWD",    MWD, (g && owner == 2) ? DWD : 32'd0);
    chk("MBE",    32'(MBE), !g ? 32'd0 : (owner == 1 ? 32'hF : 32'(DBE)));
    chk("MWE",    32'(MWE), 32'(g && owner == 2 && DWE));
    chk("ICID",   ICID, MRD);
    chk("DRD",    DRD,  MRD);
    if (MREQ && CE) grant_cyc++;
    if (BERR) begin
      n_berr++;
      chk("BERR_cycle", 32'(grant_cyc), 32'd8);
    end
    if (!MREQ) grant_cyc = 0;
    if (rec && CE && ICIACK) seq.push_back(8'h49);
    if (rec && CE && DACK)   seq.push_back(8'h44);
  endtask

  task automatic cycle();
    @(posedge CLK);
    on_edge();
    #1;
    drive();
    #1;
    check();
  endtask

  initial begin
    RES = 1'b1; CE = 1'b1; ICIREQ = 1'b0; DREQ = 1'b0; DWE = 1'b0; MACK = 1'b0;
    ICIA = 32'd0; DA = 32'd0; DWD = 32'd0; MRD = 32'd0; DBE = 4'd0;

    // Reset state.
    repeat (3) cycle();
    RES = 1'b0;

    // Instruction-only traffic, memory latency 2.
    i_en = 1'b1; lat_min = 2; lat_max = 2;
    repeat (12) cycle();
    i_en = 1'b0;
    repeat (8) cycle();

    // Both requesting continuously from the same cycle, immediate MACK.
    lat_min = 0; lat_max = 0; rec = 1'b1; i_en = 1'b1; d_en = 1'b1;
    repeat (40) cycle();
    rec = 1'b0; i_en = 1'b0; d_en = 1'b0;
    for (int i = 0; i < 10; i++)
      chk($sformatf("grant_seq%0d", i), (i < seq.size()) ? 32'(seq[i]) : 32'd0,
          32'(exp_seq[i]));
    repeat (8) cycle();

    // Watchdog: data write that memory never acknowledges.
    d_en = 1'b1; wr_only = 1'b1; no_ack = 1'b1;
    repeat (12) cycle();
    d_en = 1'b0;
    repeat (14) cycle();
    chk("BERR_seen", 32'(n_berr != 0), 32'd1);
    no_ack = 1'b0; wr_only = 1'b0;

    // Asynchronous reset in the middle of a data grant.
    lat_min = 3; lat_max = 3; d_en = 1'b1; i_en = 1'b1;
    for (int k = 0; k < 12 && !(ph == 1 && owner == 2); k++) cycle();
    chk("t5_grant_MREQ", 32'(MREQ), 32'd1);
    #1 RES = 1'b1;
    #1;
    chk("t5_async_MREQ", 32'(MREQ), 32'd0);
    chk("t5_async_DACK", 32'(DACK), 32'd0);
    chk("t5_async_MA",   MA, 32'd0);
    cycle();
    RES = 1'b0;
    repeat (20) cycle();

    // CE toggling every cycle.
    ce_alt = 1'b1; lat_min = 0; lat_max = 3;
    repeat (40) cycle();
    ce_alt = 1'b0;

    // Randomized traffic with stray MACKs and random CE.
    ce_pct = 70; noise = 1'b1; cool_max = 3; raise_pct = 50;
    repeat (600) cycle();
    i_en = 1'b0; d_en = 1'b0;
    repeat (30) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
